// File: rtl/timer_irq_scheduler.sv
// timer_irq_scheduler: latches timer interrupt pulses as pending requests,
// masks them, picks one round-robin and delivers its channel index to the
// core over a 4-phase IRQ/IACK handshake. Control registers are written
// through the ISI write port (ACT, active-low BE, DI).
module timer_irq_scheduler #(
  parameter int CHANNELS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  TINT,
  input  logic        ACT,
  input  logic [7:0]  BE,
  input  logic [63:0] DI,
  input  logic        IACK,
  output logic        IRQ,
  output logic [2:0]  IVEC,
  output logic [7:0]  PEND,
  output logic [7:0]  MASK,
  output logic [7:0]  OVF,
  output logic        GEN
);

  // Bits at or above CHANNELS never hold state.
  localparam logic [8:0] CH_ONEHOT = 9'd1 << CHANNELS;
  localparam logic [7:0] CH_MASK   = CH_ONEHOT[7:0] - 8'd1;
  localparam logic [2:0] LAST_INIT = 3'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      r_state;
  state_e      w_nextState;
  logic [7:0]  r_pend;
  logic [7:0]  r_mask;
  logic [7:0]  r_ovf;
  logic        r_gen;
  logic [2:0]  r_ivec;
  logic [2:0]  r_last;

  logic [7:0]  w_elig;
  logic [7:0]  w_isiPendClr;
  logic [7:0]  w_isiOvfClr;
  logic [7:0]  w_ackClr;
  logic [7:0]  w_pendClr;
  logic [7:0]  w_ovfSet;
  logic        w_irq;
  logic        w_load;
  logic        w_ack;
  logic        w_found;
  logic [2:0]  w_sel;
  logic [2:0]  w_idx;
  logic        w_unusedBits;

  assign w_unusedBits = ^{DI[63:32], DI[30:24], BE[7:4]};

  assign w_elig       = r_gen ? (r_pend & r_mask) : 8'h00;
  assign w_isiPendClr = (ACT && !BE[1]) ? DI[15:8]  : 8'h00;
  assign w_isiOvfClr  = (ACT && !BE[2]) ? DI[23:16] : 8'h00;
  assign w_pendClr    = w_isiPendClr | w_ackClr;
  assign w_ovfSet     = TINT & r_pend & ~w_pendClr;

  // Round-robin search: first eligible channel after the last one served.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    w_idx   = 3'd0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx = 3'((int'(r_last) + k) % CHANNELS);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // FSM next-state logic; a request, once issued, is only ended by IACK.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_elig != 8'h00) w_nextState = REQ;
      REQ:     if (IACK)            w_nextState = WAIT;
      WAIT:    if (!IACK)           w_nextState = IDLE;
      default:                      w_nextState = IDLE;
    endcase
  end

  // FSM outputs: request level, vector load strobe and acknowledge clear.
  always_comb begin
    w_irq    = (r_state == REQ);
    w_load   = (r_state == IDLE) && (w_elig != 8'h00);
    w_ack    = (r_state == REQ) && IACK;
    w_ackClr = w_ack ? ((8'b1 << r_ivec) & CH_MASK) : 8'h00;
  end

  // Vector register and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ivec <= 3'd0;
      r_last <= LAST_INIT;
    end else begin
      if (w_load) r_ivec <= w_sel;
      if (w_ack)  r_last <= r_ivec;
    end
  end

  // Pending and overflow flags; a new pulse always beats a clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pend <= 8'h00;
      r_ovf  <= 8'h00;
    end else begin
      r_pend <= ((r_pend & ~w_pendClr) | TINT) & CH_MASK;
      r_ovf  <= ((r_ovf & ~w_isiOvfClr) | w_ovfSet) & CH_MASK;
    end
  end

  // ISI-writable mask and global enable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mask <= 8'h00;
      r_gen  <= 1'b0;
    end else if (ACT) begin
      if (!BE[0]) r_mask <= DI[7:0] & CH_MASK;
      if (!BE[3]) r_gen  <= DI[31];
    end
  end

  assign IRQ  = w_irq;
  assign IVEC = r_ivec;
  assign PEND = r_pend;
  assign MASK = r_mask;
  assign OVF  = r_ovf;
  assign GEN  = r_gen;

endmodule

// File: tb/tb_timer_irq_scheduler.sv
// tb_timer_irq_scheduler: directed test of timer_irq_scheduler with
// hand-computed expectations; each step drives inputs, advances one clock
// edge and samples outputs 1 time unit later.
module tb_timer_irq_scheduler;

  logic        clk;
  logic        reset;
  logic [7:0]  tint;
  logic        act;
  logic [7:0]  be;
  logic [63:0] di;
  logic        iack;
  logic        irq;
  logic [2:0]  ivec;
  logic [7:0]  pend;
  logic [7:0]  mask;
  logic [7:0]  ovf;
  logic        gen;

  int total = 0;
  int bad   = 0;
  logic [7:0] expPend;

  timer_irq_scheduler #(.CHANNELS(4)) dut (
    .CLK   (clk),
    .RESET (reset),
    .TINT  (tint),
    .ACT   (act),
    .BE    (be),
    .DI    (di),
    .IACK  (iack),
    .IRQ   (irq),
    .IVEC  (ivec),
    .PEND  (pend),
    .MASK  (mask),
    .OVF   (ovf),
    .GEN   (gen)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, then return ACT/TINT to idle.
  // IACK keeps the level given here until the next call changes it.
  task automatic applyStimulus(input logic a, input logic [7:0] b, input logic [63:0] d,
                               input logic [7:0] t, input logic ack);
    act  = a;
    be   = b;
    di   = d;
    tint = t;
    iack = ack;
    @(posedge clk);
    #1;
    act  = 1'b0;
    be   = 8'hFF;
    di   = 64'h0;
    tint = 8'h00;
  endtask

  task automatic idleStep(input logic ack);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h00, ack);
  endtask

  task automatic doReset();
    reset = 1'b0;
    act   = 1'b0;
    be    = 8'hFF;
    di    = 64'h0;
    tint  = 8'h00;
    iack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    // Test 1: single request through the full handshake.
    checkOutput("rst irq",  {7'b0, irq}, 8'h00);
    checkOutput("rst ivec", {5'b0, ivec}, 8'h00);
    checkOutput("rst pend", pend, 8'h00);
    checkOutput("rst mask", mask, 8'h00);
    checkOutput("rst ovf",  ovf,  8'h00);
    checkOutput("rst gen",  {7'b0, gen}, 8'h00);
    applyStimulus(1'b1, 8'hF6, 64'h0000_0000_8000_0001, 8'h00, 1'b0);
    checkOutput("t1 mask", mask, 8'h01);
    checkOutput("t1 gen",  {7'b0, gen}, 8'h01);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h01, 1'b0);
    checkOutput("t1 pend n+1", pend, 8'h01);
    checkOutput("t1 irq n+1",  {7'b0, irq}, 8'h00);
    idleStep(1'b0);
    checkOutput("t1 irq n+2",  {7'b0, irq}, 8'h01);
    checkOutput("t1 ivec n+2", {5'b0, ivec}, 8'h00);
    idleStep(1'b1);
    checkOutput("t1 irq ack",  {7'b0, irq}, 8'h00);
    checkOutput("t1 pend ack", pend, 8'h00);
    idleStep(1'b1);
    checkOutput("t1 irq wait", {7'b0, irq}, 8'h00);
    idleStep(1'b0);
    checkOutput("t1 irq idle", {7'b0, irq}, 8'h00);

    // Test 2: round robin from reset, then wrap with LAST=3.
    doReset();
    applyStimulus(1'b1, 8'hF6, 64'h0000_0000_8000_000F, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h0F, 1'b0);
    expPend = 8'h0F;
    checkOutput("t2 pend", pend, expPend);
    idleStep(1'b0);
    checkOutput("t2 irq first",  {7'b0, irq}, 8'h01);
    checkOutput("t2 ivec first", {5'b0, ivec}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      idleStep(1'b1);
      expPend[k] = 1'b0;
      checkOutput("t2 irq ack",  {7'b0, irq}, 8'h00);
      checkOutput("t2 pend ack", pend, expPend);
      idleStep(1'b0);
      checkOutput("t2 irq wait", {7'b0, irq}, 8'h00);
      if (k < 3) begin
        idleStep(1'b0);
        checkOutput("t2 irq next",  {7'b0, irq}, 8'h01);
        checkOutput("t2 ivec next", {5'b0, ivec}, 8'(k + 1));
      end
    end
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h05, 1'b0);
    idleStep(1'b0);
    checkOutput("t2 wrap ivec a", {5'b0, ivec}, 8'h00);
    idleStep(1'b1);
    idleStep(1'b0);
    idleStep(1'b0);
    checkOutput("t2 wrap irq b",  {7'b0, irq}, 8'h01);
    checkOutput("t2 wrap ivec b", {5'b0, ivec}, 8'h02);
    idleStep(1'b1);
    idleStep(1'b0);
    checkOutput("t2 pend end", pend, 8'h00);

    // Test 3: overflow on a masked channel, then W1C of OVF only.
    applyStimulus(1'b1, 8'hFE, 64'h0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h02, 1'b0);
    checkOutput("t3 ovf once", ovf, 8'h00);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h02, 1'b0);
    checkOutput("t3 pend", pend, 8'h02);
    checkOutput("t3 ovf",  ovf,  8'h02);
    checkOutput("t3 irq masked", {7'b0, irq}, 8'h00);
    applyStimulus(1'b1, 8'hFB, 64'h0000_0000_0002_0000, 8'h00, 1'b0);
    checkOutput("t3 ovf clr",  ovf,  8'h00);
    checkOutput("t3 pend kept", pend, 8'h02);
    applyStimulus(1'b1, 8'hFD, 64'h0000_0000_0000_0200, 8'h00, 1'b0);
    checkOutput("t3 pend clr", pend, 8'h00);

    // Test 4: pulse on the acknowledged channel survives the ack clear.
    applyStimulus(1'b1, 8'hFE, 64'h0000_0000_0000_0004, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h04, 1'b0);
    idleStep(1'b0);
    checkOutput("t4 irq",  {7'b0, irq}, 8'h01);
    checkOutput("t4 ivec", {5'b0, ivec}, 8'h02);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h04, 1'b1);
    checkOutput("t4 pend kept", pend, 8'h04);
    checkOutput("t4 ovf zero",  ovf,  8'h00);
    checkOutput("t4 irq ack",   {7'b0, irq}, 8'h00);
    idleStep(1'b0);
    checkOutput("t4 irq wait",  {7'b0, irq}, 8'h00);
    idleStep(1'b0);
    checkOutput("t4 irq again",  {7'b0, irq}, 8'h01);
    checkOutput("t4 ivec again", {5'b0, ivec}, 8'h02);
    idleStep(1'b1);
    idleStep(1'b0);

    // Test 5: request held while MASK and GEN drop; GEN=0 blocks new ones.
    applyStimulus(1'b1, 8'hFE, 64'h0000_0000_0000_0002, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h02, 1'b0);
    idleStep(1'b0);
    checkOutput("t5 ivec", {5'b0, ivec}, 8'h01);
    applyStimulus(1'b1, 8'hF6, 64'h0, 8'h00, 1'b0);
    checkOutput("t5 mask off", mask, 8'h00);
    checkOutput("t5 gen off",  {7'b0, gen}, 8'h00);
    checkOutput("t5 irq held", {7'b0, irq}, 8'h01);
    idleStep(1'b0);
    checkOutput("t5 irq held2",  {7'b0, irq}, 8'h01);
    checkOutput("t5 ivec held2", {5'b0, ivec}, 8'h01);
    idleStep(1'b1);
    checkOutput("t5 pend ack", pend, 8'h00);
    idleStep(1'b0);
    applyStimulus(1'b1, 8'hFE, 64'h0000_0000_0000_0002, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h02, 1'b0);
    repeat (3) idleStep(1'b0);
    checkOutput("t5 irq gated",  {7'b0, irq}, 8'h00);
    checkOutput("t5 pend gated", pend, 8'h02);

    // Test 6: asynchronous reset in the middle of a request.
    applyStimulus(1'b1, 8'hF6, 64'h0000_0000_8000_0003, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h01, 1'b0);
    checkOutput("t6 irq pre",  {7'b0, irq}, 8'h01);
    checkOutput("t6 ivec pre", {5'b0, ivec}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6 irq async",  {7'b0, irq}, 8'h00);
    checkOutput("t6 pend async", pend, 8'h00);
    checkOutput("t6 mask async", mask, 8'h00);
    checkOutput("t6 gen async",  {7'b0, gen}, 8'h00);
    checkOutput("t6 ivec async", {5'b0, ivec}, 8'h00);
    #2;
    reset = 1'b1;
    applyStimulus(1'b1, 8'hF6, 64'h0000_0000_8000_0003, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hFF, 64'h0, 8'h03, 1'b0);
    idleStep(1'b0);
    checkOutput("t6 first irq",  {7'b0, irq}, 8'h01);
    checkOutput("t6 first ivec", {5'b0, ivec}, 8'h00);
    idleStep(1'b1);
    idleStep(1'b0);
    idleStep(1'b0);
    checkOutput("t6 second ivec", {5'b0, ivec}, 8'h01);
    idleStep(1'b1);
    idleStep(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
